// File: rtl/onewire_temp_responder.sv
// 1-Wire slave: reset/presence, LSB-first command receive (SKIP ROM, CONVERT T, READ SCRATCHPAD), 16-bit read-back.
// Outputs are registered (cmd_valid one cycle after the 8th sample); no backpressure, the bus master sets all timing.
module onewire_temp_responder #(
    parameter int CLK_MHZ      = 10,
    parameter int RESET_MIN_US = 480,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_LEN_US  = 120,
    parameter int SAMPLE_US    = 30,
    parameter int HOLD_US      = 30
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        dq_in,
    output logic        dq_pull_low,
    input  logic [15:0] temp_data,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        conv_start,
    output logic        busy
);
    localparam int RESET_CYC = RESET_MIN_US * CLK_MHZ;
    localparam int PW_CYC    = PRES_WAIT_US * CLK_MHZ;
    localparam int PL_CYC    = PRES_LEN_US * CLK_MHZ;
    localparam int SMP_CYC   = SAMPLE_US * CLK_MHZ;
    localparam int HOLD_CYC  = HOLD_US * CLK_MHZ;
    localparam int CW        = $clog2(RESET_CYC + 1);
    localparam int TW        = $clog2(PW_CYC + PL_CYC + SMP_CYC + HOLD_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, PRES_WAIT, PRESENCE, ROM_CMD, FUNC_CMD, TX
    } state_t;

    state_t          state_q, state_d;
    logic            dq_m_q, dq_m_d, dq_s_q, dq_s_d, dq_p_q, dq_p_d;
    logic [CW-1:0]   low_cnt_q, low_cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            slot_q, slot_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      sr_q, sr_d;
    logic [15:0]     tx_q, tx_d;
    logic [1:0]      sup_q, sup_d;
    logic            pull_q, pull_d;
    logic [7:0]      cmd_byte_q, cmd_byte_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            conv_q, conv_d;
    logic            busy_q, busy_d;

    logic            fall, rise, low_sat, edge_ok;
    logic [7:0]      rx_byte;

    assign fall    = dq_p_q & ~dq_s_q;
    assign rise    = ~dq_p_q & dq_s_q;
    assign low_sat = (low_cnt_q == CW'(RESET_CYC));
    // Our own drive (and its 2-cycle echo through the synchroniser) must never look like a slot.
    assign edge_ok = fall & ~pull_q & (sup_q == 2'd0);
    assign rx_byte = {dq_s_q, sr_q[7:1]};

    always_comb begin
        dq_m_d      = dq_in;
        dq_s_d      = dq_m_q;
        dq_p_d      = dq_s_q;
        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        tmr_d       = tmr_q;
        slot_d      = slot_q;
        bit_d       = bit_q;
        sr_d        = sr_q;
        tx_d        = tx_q;
        pull_d      = pull_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        conv_d      = 1'b0;

        if (dq_s_q) begin
            low_cnt_d = '0;
        end else if (!pull_q && !low_sat) begin
            low_cnt_d = low_cnt_q + 1'b1;
        end

        if (pull_q) begin
            sup_d = 2'd2;
        end else if (sup_q != 2'd0) begin
            sup_d = sup_q - 2'd1;
        end else begin
            sup_d = 2'd0;
        end

        case (state_q)
            PRES_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TW'(PW_CYC - 1)) begin
                    state_d = PRESENCE;
                    tmr_d   = '0;
                    pull_d  = 1'b1;
                end
            end
            PRESENCE: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TW'(PL_CYC - 1)) begin
                    state_d = ROM_CMD;
                    tmr_d   = '0;
                    pull_d  = 1'b0;
                    slot_d  = 1'b0;
                    bit_d   = '0;
                end
            end
            ROM_CMD, FUNC_CMD: begin
                if (slot_q) begin
                    tmr_d = tmr_q + 1'b1;
                    if (tmr_q == TW'(SMP_CYC)) begin
                        slot_d = 1'b0;
                        sr_d   = rx_byte;
                        bit_d  = bit_q + 4'd1;
                        if (bit_q == 4'd7) begin
                            bit_d       = '0;
                            cmd_byte_d  = rx_byte;
                            cmd_valid_d = 1'b1;
                            state_d     = IDLE;
                            if (state_q == ROM_CMD) begin
                                if (rx_byte == 8'hCC) state_d = FUNC_CMD;
                            end else if (rx_byte == 8'h44) begin
                                conv_d = 1'b1;
                            end else if (rx_byte == 8'hBE) begin
                                tx_d    = temp_data;
                                state_d = TX;
                            end
                        end
                    end
                end else if (edge_ok) begin
                    slot_d = 1'b1;
                    tmr_d  = '0;
                end
            end
            TX: begin
                if (slot_q || pull_q) tmr_d = tmr_q + 1'b1;
                if (pull_q && tmr_q == TW'(HOLD_CYC - 1)) pull_d = 1'b0;
                if (slot_q) begin
                    if (tmr_q == TW'(SMP_CYC)) begin
                        slot_d = 1'b0;
                        bit_d  = bit_q + 4'd1;
                        if (bit_q == 4'd15) begin
                            bit_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end else if (edge_ok) begin
                    slot_d = 1'b1;
                    tmr_d  = '0;
                    pull_d = ~tx_q[bit_q];
                end
            end
            default: ;
        endcase

        // A long low takes priority over whatever was in progress.
        if (rise && low_sat) begin
            state_d     = PRES_WAIT;
            tmr_d       = '0;
            slot_d      = 1'b0;
            bit_d       = '0;
            sr_d        = '0;
            pull_d      = 1'b0;
            cmd_byte_d  = cmd_byte_q;
            cmd_valid_d = 1'b0;
            conv_d      = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            dq_m_q      <= 1'b1;
            dq_s_q      <= 1'b1;
            dq_p_q      <= 1'b1;
            low_cnt_q   <= '0;
            tmr_q       <= '0;
            slot_q      <= 1'b0;
            bit_q       <= '0;
            sr_q        <= '0;
            tx_q        <= '0;
            sup_q       <= '0;
            pull_q      <= 1'b0;
            cmd_byte_q  <= '0;
            cmd_valid_q <= 1'b0;
            conv_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dq_m_q      <= dq_m_d;
            dq_s_q      <= dq_s_d;
            dq_p_q      <= dq_p_d;
            low_cnt_q   <= low_cnt_d;
            tmr_q       <= tmr_d;
            slot_q      <= slot_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            tx_q        <= tx_d;
            sup_q       <= sup_d;
            pull_q      <= pull_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            conv_q      <= conv_d;
            busy_q      <= busy_d;
        end
    end

    assign dq_pull_low = pull_q;
    assign cmd_byte    = cmd_byte_q;
    assign cmd_valid   = cmd_valid_q;
    assign conv_start  = conv_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_onewire_temp_responder.sv
// Directed bench for onewire_temp_responder: bus master model on a wired-AND line, scoreboard of expected bytes/bits.
module tb_onewire_temp_responder;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        master_low = 1'b0;
    logic        dq_in;
    logic [15:0] temp_data = 16'h0000;
    logic        dq_pull_low, cmd_valid, conv_start, busy;
    logic [7:0]  cmd_byte;

    assign dq_in = ~(master_low | dq_pull_low);

    onewire_temp_responder #(.CLK_MHZ(10)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .dq_in      (dq_in),
        .dq_pull_low(dq_pull_low),
        .temp_data  (temp_data),
        .cmd_byte   (cmd_byte),
        .cmd_valid  (cmd_valid),
        .conv_start (conv_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         conv_cnt = 0;
    logic [7:0] exp_cmd[$];
    logic       exp_bits[$];
    logic       cv_prev = 1'b0;
    logic       cs_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every cmd_valid must match the oldest expected byte.
    always @(negedge clk) begin
        if (nrst) begin
            if (cmd_valid) begin
                chk("cmd_expected", 32'(exp_cmd.size() != 0), 1);
                if (exp_cmd.size() != 0) chk("cmd_byte", cmd_byte, exp_cmd.pop_front());
                chk("cmd_valid_width", cv_prev, 0);
            end
            if (conv_start) begin
                conv_cnt++;
                chk("conv_with_cmd", {cmd_valid, cmd_byte}, {1'b1, 8'h44});
                chk("conv_width", cs_prev, 0);
            end
        end
        cv_prev = cmd_valid;
        cs_prev = conv_start;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        master_low = 1'b1;
        cyc(b ? 50 : 600);
        master_low = 1'b0;
        cyc(b ? 350 : 20);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic read_bit(output logic b);
        master_low = 1'b1;
        cyc(20);
        master_low = 1'b0;
        cyc(130);
        b = dq_in;
        cyc(250);
    endtask

    task automatic measure_presence(input string tag);
        int n;
        n = 0;
        while (!dq_pull_low && n < 400) begin
            cyc(1);
            n++;
        end
        chk({tag, "_pres_delay_in_301_304"}, 32'(n >= 301 && n <= 304), 1);
        n = 0;
        while (dq_pull_low && n < 1300) begin
            cyc(1);
            n++;
        end
        chk({tag, "_pres_len"}, n, 1200);
        cyc(50);
        chk({tag, "_busy_rom"}, busy, 1);
    endtask

    task automatic reset_presence(input string tag);
        master_low = 1'b1;
        cyc(4800);
        master_low = 1'b0;
        measure_presence(tag);
    endtask

    task automatic push_bits(input logic [15:0] v);
        for (int i = 0; i < 16; i++) exp_bits.push_back(v[i]);
    endtask

    initial begin
        logic b;
        cyc(3);
        chk("rst_pull", dq_pull_low, 0);
        chk("rst_cmd_byte", cmd_byte, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_conv", conv_start, 0);
        chk("rst_busy", busy, 0);
        nrst = 1'b1;
        cyc(5);

        // Reset/presence, then SKIP ROM + CONVERT T
        reset_presence("t1");
        exp_cmd.push_back(8'hCC);
        exp_cmd.push_back(8'h44);
        write_byte(8'hCC);
        write_byte(8'h44);
        cyc(10);
        chk("t2_conv_cnt", conv_cnt, 1);
        chk("t2_busy_idle", busy, 0);
        chk("t2_cmd_byte", cmd_byte, 8'h44);
        chk("t2_queue_empty", exp_cmd.size(), 0);

        // READ SCRATCHPAD, temp_data changed mid-transmit
        reset_presence("t3");
        temp_data = 16'h0191;
        exp_cmd.push_back(8'hCC);
        exp_cmd.push_back(8'hBE);
        write_byte(8'hCC);
        write_byte(8'hBE);
        chk("t3_busy_tx", busy, 1);
        push_bits(16'h0191);
        for (int i = 0; i < 16; i++) begin
            read_bit(b);
            if (i == 4) temp_data = 16'hFFFF;
            chk($sformatf("t3_rd_bit%0d", i), b, exp_bits.pop_front());
        end
        cyc(10);
        chk("t3_busy_idle", busy, 0);
        chk("t3_conv_cnt", conv_cnt, 1);

        // Unknown ROM command, later slots ignored
        reset_presence("t5");
        exp_cmd.push_back(8'h33);
        write_byte(8'h33);
        cyc(5);
        chk("t5_busy_idle", busy, 0);
        chk("t5_cmd_byte", cmd_byte, 8'h33);
        write_byte(8'hFF);
        cyc(5);
        chk("t5_ignored_busy", busy, 0);
        chk("t5_ignored_cmd", cmd_byte, 8'h33);
        chk("t5_conv_cnt", conv_cnt, 1);

        // Reset pulse during the 4th transmitted bit
        temp_data = 16'h0191;
        reset_presence("t6");
        exp_cmd.push_back(8'hCC);
        exp_cmd.push_back(8'hBE);
        write_byte(8'hCC);
        write_byte(8'hBE);
        push_bits(16'h0191);
        for (int i = 0; i < 3; i++) begin
            read_bit(b);
            chk($sformatf("t6_rd_bit%0d", i), b, exp_bits.pop_front());
        end
        exp_bits.delete();
        master_low = 1'b1;
        cyc(5990);
        chk("t6_drive_released", dq_pull_low, 0);
        chk("t6_busy_tx", busy, 1);
        cyc(10);
        master_low = 1'b0;
        measure_presence("t6r");

        // Async reset mid-byte clears every output at once
        write_bit(1'b0);
        write_bit(1'b1);
        master_low = 1'b1;
        cyc(100);
        chk("t7_busy_before", busy, 1);
        chk("t7_cmd_before", cmd_byte, 8'hBE);
        nrst = 1'b0;
        #1;
        chk("t7_pull", dq_pull_low, 0);
        chk("t7_cmd_byte", cmd_byte, 0);
        chk("t7_cmd_valid", cmd_valid, 0);
        chk("t7_conv", conv_start, 0);
        chk("t7_busy", busy, 0);
        master_low = 1'b0;
        cyc(5);
        nrst = 1'b1;
        cyc(5);
        chk("t7_busy_after", busy, 0);

        chk("end_queue_empty", exp_cmd.size(), 0);
        chk("end_conv_cnt", conv_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
